idct_block_scheduler: RTL and testbench

Flow-control controller for the two-pass 8x8 IDCT pipeline. That pipeline has fixed latency and no backpressure.
- Accepts coefficient blocks from the dequantiser over valid/ready and issues them into the pipeline only when result storage is guaranteed.
- Captures returning blocks in a result FIFO and re-attaches each block's sideband tag (component/MCU index).
- Presents results downstream over valid/ready, with sticky error flags for protocol faults.

---
 rtl/idct_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 52 +++++
 rtl/idct_block_scheduler.sv | 125 ++++++++++++
 tb/tb_idct_block_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idct_pkg.sv
// rtl/idct_pkg.sv - shared constants and types for the IDCT block scheduler
// Contents: block/coefficient widths, err bit indices, default tag-queue entry type.
package idct_pkg;

   localparam int IDCT_BLK_W  = 512;  // 64 coefficients x 8 bits
   localparam int IDCT_COEF_W = 8;

   // Bit positions inside the sticky err vector
   localparam int ERR_UNEXP = 0;      // result returned with nothing in flight
   localparam int ERR_OVF   = 1;      // result dropped because the result FIFO was full
   localparam int ERR_TMO   = 2;      // oldest in-flight block exceeded MAX_LAT
   localparam int ERR_W     = 3;

   localparam int TAG_W_DEF = 4;
   localparam int TS_W_DEF  = 8;

   // Tag-queue entry at the default widths: sideband tag plus issue timestamp
   typedef struct packed {
      logic [TAG_W_DEF-1:0] tag;
      logic [TS_W_DEF-1:0]  ts;
   } idct_tag_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count
// Ports: clk, rst (async active-low); push/push_data write side; pop/pop_data
// read side (pop_data is the head entry, zero when empty); count, full, empty.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
   parameter  int W     = 8,
   parameter  int DEPTH = 4,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic [W-1:0]  pop_data,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   // Head is forced to zero while empty so stale storage never leaks out
   assign pop_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/idct_block_scheduler.sv
// rtl/idct_block_scheduler.sv - credit-based issue/return scheduler for the 8x8 IDCT pipeline
// Ports: clk, rst (async active-low); s_valid/s_ready/s_data/s_tag upstream blocks;
// idct_valid/idct_data issue strobe; idct_out_valid/idct_out_data pipeline results;
// m_valid/m_ready/m_data/m_tag downstream results; busy; err sticky {tmo, ovf, unexp}.
module idct_block_scheduler
   import idct_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 4,
   parameter int MAX_LAT = 64,
   parameter int TS_W    = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [IDCT_BLK_W-1:0] s_data,
   input  logic [TAG_W-1:0]      s_tag,
   output logic                  idct_valid,
   output logic [IDCT_BLK_W-1:0] idct_data,
   input  logic                  idct_out_valid,
   input  logic [IDCT_BLK_W-1:0] idct_out_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [IDCT_BLK_W-1:0] m_data,
   output logic [TAG_W-1:0]      m_tag,
   output logic                  busy,
   output logic [ERR_W-1:0]      err
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int RW = IDCT_BLK_W + TAG_W;
   localparam logic [TS_W-1:0] MAX_LAT_TS = TS_W'(MAX_LAT);

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [TS_W-1:0]  ts;
   } tq_ent_t;

   tq_ent_t          tq_push_ent;
   tq_ent_t          tq_head;
   logic [CW-1:0]    in_flight;   // tag-queue occupancy is exactly the in-flight count
   logic             tq_full;
   logic             tq_empty;

   logic [RW-1:0]    rf_push_ent;
   logic [RW-1:0]    rf_head;
   logic [CW-1:0]    rf_count;
   logic             rf_full;
   logic             rf_empty;
   logic             rf_push;
   logic             rf_pop;

   logic [TS_W-1:0]  ts;
   logic [TS_W-1:0]  age;
   logic [CW-1:0]    credits;
   logic             issue;
   logic             ret;
   logic [ERR_W-1:0] err_set;

   // Every accepted block has a reserved result slot: in-flight plus buffered never exceeds DEPTH
   assign credits = CW'(DEPTH) - rf_count - in_flight;
   assign s_ready = (credits != '0) && !tq_full;
   assign issue   = s_valid && s_ready;

   assign ret     = idct_out_valid && (in_flight != '0);
   assign rf_pop  = !rf_empty && m_ready;
   assign rf_push = ret && (!rf_full || rf_pop);

   // Modular age keeps the comparison correct across timestamp wrap
   assign age     = ts - tq_head.ts;

   always_comb begin
      err_set            = '0;
      err_set[ERR_UNEXP] = idct_out_valid && (in_flight == '0);
      err_set[ERR_OVF]   = ret && rf_full && !rf_pop;
      err_set[ERR_TMO]   = (in_flight != '0) && (age > MAX_LAT_TS);
   end

   assign tq_push_ent = '{tag: s_tag, ts: ts};
   assign rf_push_ent = {idct_out_data, tq_head.tag};
   assign {m_data, m_tag} = rf_head;
   assign m_valid = !rf_empty;
   assign busy    = (in_flight != '0) || !rf_empty;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ts         <= '0;
         idct_valid <= 1'b0;
         idct_data  <= '0;
         err        <= '0;
      end else begin
         ts         <= ts + TS_W'(1);
         idct_valid <= issue;
         if (issue) idct_data <= s_data;
         err        <= err | err_set;
      end
   end

   // Tag queue: popped on every accepted return, even one whose data is dropped
   sync_fifo #(.W(TAG_W + TS_W), .DEPTH(DEPTH)) u_tag_q (
      .clk       (clk),
      .rst       (rst),
      .push      (issue),
      .push_data (tq_push_ent),
      .pop       (ret),
      .pop_data  (tq_head),
      .count     (in_flight),
      .full      (tq_full),
      .empty     (tq_empty)
   );

   sync_fifo #(.W(RW), .DEPTH(DEPTH)) u_res_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (rf_push),
      .push_data (rf_push_ent),
      .pop       (rf_pop),
      .pop_data  (rf_head),
      .count     (rf_count),
      .full      (rf_full),
      .empty     (rf_empty)
   );

endmodule

// File: tb/tb_idct_block_scheduler.sv
// tb/tb_idct_block_scheduler.sv - randomized reference-model bench for idct_block_scheduler
module tb_idct_block_scheduler;
   import idct_pkg::*;

   localparam int DEPTH = 4;
   localparam int MAXL  = 64;
   localparam logic [IDCT_BLK_W-1:0] MASK = {16{32'hC3A5_965A}};

   logic                  clk = 1'b0;
   logic                  rst = 1'b0;
   logic                  s_valid = 1'b0;
   logic                  s_ready;
   logic [IDCT_BLK_W-1:0] s_data = '0;
   logic [3:0]            s_tag = '0;
   logic                  idct_valid;
   logic [IDCT_BLK_W-1:0] idct_data;
   logic                  idct_out_valid = 1'b0;
   logic [IDCT_BLK_W-1:0] idct_out_data = '0;
   logic                  m_valid;
   logic                  m_ready = 1'b0;
   logic [IDCT_BLK_W-1:0] m_data;
   logic [3:0]            m_tag;
   logic                  busy;
   logic [2:0]            err;

   idct_block_scheduler #(.DEPTH(DEPTH), .TAG_W(4), .MAX_LAT(MAXL), .TS_W(8)) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_tag(s_tag),
      .idct_valid(idct_valid), .idct_data(idct_data),
      .idct_out_valid(idct_out_valid), .idct_out_data(idct_out_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_tag(m_tag),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   task automatic check_eq(input string name, input logic [511:0] got, input logic [511:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [IDCT_BLK_W-1:0] rnd512();
      logic [IDCT_BLK_W-1:0] r;
      for (int i = 0; i < IDCT_BLK_W / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Fixed-latency IDCT pipeline model: result = block ^ MASK, lat cycles after idct_valid
   int  lat = 20;
   int  cyc = 0;
   bit  spur_req = 1'b0;
   logic [IDCT_BLK_W-1:0] pq[$];
   int  dq[$];

   initial begin
      forever begin
         @(posedge clk); #1;
         cyc++;
         if (idct_valid) begin
            pq.push_back(idct_data ^ MASK);
            dq.push_back(cyc + lat);
         end
         if (spur_req) begin
            idct_out_valid = 1'b1;
            idct_out_data  = rnd512();
            spur_req       = 1'b0;
         end else if (dq.size() != 0 && dq[0] == cyc) begin
            idct_out_valid = 1'b1;
            idct_out_data  = pq.pop_front();
            void'(dq.pop_front());
         end else begin
            idct_out_valid = 1'b0;
         end
      end
   end

   // Scheduler reference: counts of held blocks, ordered result/tag queues, issue-edge ages
   int  infl = 0;
   int  ecnt = 0;
   logic [IDCT_BLK_W-1:0] rq_d[$];
   logic [3:0]            rq_t[$];
   logic [3:0]            tq_t[$];
   int                    tq_e[$];
   logic                  exp_iv  = 1'b0;
   logic [IDCT_BLK_W-1:0] exp_id  = '0;
   logic [2:0]            exp_err = '0;

   initial begin
      logic exp_sr;
      logic pop;
      forever begin
         @(negedge clk);
         ecnt++;
         if (!rst) begin
            infl = 0; rq_d.delete(); rq_t.delete(); tq_t.delete(); tq_e.delete();
            exp_iv = 1'b0; exp_id = '0; exp_err = '0;
            continue;
         end
         exp_sr = (infl + rq_d.size()) < DEPTH;
         check_eq("s_ready", s_ready, exp_sr);
         check_eq("m_valid", m_valid, rq_d.size() != 0);
         if (rq_d.size() != 0) begin
            check_eq("m_data", m_data, rq_d[0]);
            check_eq("m_tag", m_tag, rq_t[0]);
         end
         check_eq("idct_valid", idct_valid, exp_iv);
         check_eq("idct_data", idct_data, exp_id);
         check_eq("busy", busy, (infl != 0) || (rq_d.size() != 0));
         check_eq("err", err, exp_err);
         // Effects of the coming clock edge
         pop = (rq_d.size() != 0) && m_ready;
         if (infl > 0 && (ecnt - tq_e[0]) > MAXL) exp_err[2] = 1'b1;
         if (idct_out_valid) begin
            if (infl == 0) exp_err[0] = 1'b1;
            else begin
               if (rq_d.size() == DEPTH && !pop) exp_err[1] = 1'b1;
               else begin
                  rq_d.push_back(idct_out_data);
                  rq_t.push_back(tq_t[0]);
               end
               void'(tq_t.pop_front());
               void'(tq_e.pop_front());
               infl--;
            end
         end
         if (pop) begin
            void'(rq_d.pop_front());
            void'(rq_t.pop_front());
         end
         exp_iv = s_valid && exp_sr;
         if (exp_iv) begin
            exp_id = s_data;
            tq_t.push_back(s_tag);
            tq_e.push_back(ecnt);
            infl++;
         end
      end
   end

   logic smp_sr, smp_mv, smp_mr, smp_iv;
   logic [3:0] smp_tag;
   int   idx;

   task automatic step();
      @(negedge clk);
      smp_sr = s_ready; smp_mv = m_valid; smp_mr = m_ready; smp_tag = m_tag; smp_iv = idct_valid;
      @(posedge clk); #1;
   endtask

   task automatic send_one(input logic [3:0] tag, input logic [IDCT_BLK_W-1:0] data);
      bit ok = 1'b0;
      s_valid = 1'b1; s_tag = tag; s_data = data;
      for (int c = 0; c < 40 && !ok; c++) begin
         step();
         if (smp_sr) ok = 1'b1;
      end
      s_valid = 1'b0;
      check_eq("accept_timeout", ok, 1'b1);
   endtask

   task automatic wait_idle(input string name);
      for (int c = 0; c < 300 && busy; c++) step();
      check_eq(name, busy, 1'b0);
   endtask

   task automatic stream_advance();
      if (s_valid && smp_sr) begin
         idx++;
         if (idx < 10) begin s_tag = idx[3:0]; s_data = rnd512(); end
         else s_valid = 1'b0;
      end
   endtask

   initial begin
      logic [IDCT_BLK_W-1:0] blk;
      logic [3:0] got[$];
      int k, n_iv;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_s_ready", s_ready, 1'b1);
      check_eq("rst_idct_valid", idct_valid, 1'b0);
      check_eq("rst_idct_data", idct_data, '0);
      check_eq("rst_m_valid", m_valid, 1'b0);
      check_eq("rst_m_data", m_data, '0);
      check_eq("rst_m_tag", m_tag, 4'h0);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_err", err, 3'b000);
      rst = 1'b1;
      step();

      // Single block, latency 20, tag 3
      lat = 20; m_ready = 1'b1;
      for (int i = 0; i < IDCT_BLK_W / IDCT_COEF_W; i++) blk[i*IDCT_COEF_W +: IDCT_COEF_W] = 8'(i * 3 + 1);
      send_one(4'h3, blk);
      check_eq("single_iv", idct_valid, 1'b1);
      check_eq("single_idata", idct_data, blk);
      k = 0;
      for (int c = 0; c < 40 && !m_valid; c++) begin step(); k++; end
      check_eq("single_lat", k, 21);
      check_eq("single_tag", m_tag, 4'h3);
      check_eq("single_data", m_data, blk ^ MASK);
      step();
      check_eq("single_mv_off", m_valid, 1'b0);
      check_eq("single_busy", busy, 1'b0);
      check_eq("single_err", err, 3'b000);

      // Ten back-to-back blocks with downstream stalled
      lat = 5; m_ready = 1'b0; idx = 0; n_iv = 0;
      s_valid = 1'b1; s_tag = 4'h0; s_data = rnd512();
      repeat (30) begin
         step();
         if (smp_iv) n_iv++;
         stream_advance();
      end
      check_eq("stall_accepts", idx, 4);
      check_eq("stall_issues", n_iv, 4);
      check_eq("stall_s_ready", s_ready, 1'b0);
      m_ready = 1'b1;
      for (int c = 0; c < 400 && got.size() < 10; c++) begin
         step();
         if (smp_mv && smp_mr) got.push_back(smp_tag);
         stream_advance();
      end
      check_eq("drain_count", got.size(), 10);
      for (int i = 0; i < got.size(); i++) check_eq("drain_order", got[i], i);
      wait_idle("drain_idle");

      // Issue and return in the same cycle
      lat = 2; m_ready = 1'b0; got.delete();
      send_one(4'hA, rnd512());
      step(); step();
      s_valid = 1'b1; s_tag = 4'hB; s_data = rnd512();
      step();
      check_eq("same_accept", smp_sr, 1'b1);
      s_valid = 1'b0;
      check_eq("same_busy", busy, 1'b1);
      check_eq("same_s_ready", s_ready, 1'b1);
      check_eq("same_head", m_tag, 4'hA);
      repeat (5) step();
      check_eq("same_hold_tag", m_tag, 4'hA);
      check_eq("same_hold_sr", s_ready, 1'b1);
      m_ready = 1'b1;
      for (int c = 0; c < 20 && got.size() < 2; c++) begin
         step();
         if (smp_mv && smp_mr) got.push_back(smp_tag);
      end
      check_eq("same_n", got.size(), 2);
      if (got.size() == 2) begin
         check_eq("same_first", got[0], 4'hA);
         check_eq("same_second", got[1], 4'hB);
      end
      wait_idle("same_idle");

      // Randomized traffic at two latencies
      foreach (dq[i]) check_eq("model_empty", dq.size(), 0);
      for (int p = 0; p < 2; p++) begin
         lat = (p == 0) ? 1 : 6;
         s_valid = 1'b0;
         for (int c = 0; c < 300; c++) begin
            step();
            if (!s_valid || smp_sr) begin
               s_valid = 1'($urandom_range(0, 1));
               s_tag   = 4'($urandom_range(0, 15));
               s_data  = rnd512();
            end
            m_ready = 1'($urandom_range(0, 1));
         end
         s_valid = 1'b0; m_ready = 1'b1;
         wait_idle("rand_idle");
      end

      // Spurious return with nothing issued
      spur_req = 1'b1;
      repeat (3) step();
      check_eq("spur_err", err, 3'b001);
      check_eq("spur_m_valid", m_valid, 1'b0);
      check_eq("spur_busy", busy, 1'b0);
      rst = 1'b0; #1;
      check_eq("spur_rst_err", err, 3'b000);
      @(posedge clk); #1; rst = 1'b1;
      step();

      // Timeout, then asynchronous reset mid-flight
      lat = 70; m_ready = 1'b1;
      send_one(4'h5, rnd512());
      repeat (64) step();
      check_eq("tmo_before", err, 3'b000);
      step();
      check_eq("tmo_set", err, 3'b100);
      repeat (3) step();
      check_eq("tmo_sticky", err, 3'b100);
      rst = 1'b0; #1;
      check_eq("arst_err", err, 3'b000);
      check_eq("arst_idct_valid", idct_valid, 1'b0);
      check_eq("arst_idct_data", idct_data, '0);
      check_eq("arst_m_valid", m_valid, 1'b0);
      check_eq("arst_m_data", m_data, '0);
      check_eq("arst_m_tag", m_tag, 4'h0);
      check_eq("arst_busy", busy, 1'b0);
      @(posedge clk); #1; rst = 1'b1;
      repeat (10) step();
      check_eq("late_ret_err", err, 3'b001);
      check_eq("late_ret_mv", m_valid, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
